// File: rtl/onehot_to_binary_16.sv
// onehot_to_binary_16
//   Unpack stage behind the one-hot quaternary adder. Each accepted 32-bit
//   word holds eight base-4 digits, one nibble per digit, one-hot encoded.
//   Every word is checked digit by digit, converted to a 16-bit binary value
//   and queued in a 2-entry FIFO behind a valid/ready handshake. A saturating
//   counter records how many accepted words held malformed digits.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset
//   in_valid   in   1   in_data holds a result word
//   in_ready   out  1   a word can be accepted this cycle
//   in_data    in   32  digit k in bits [4k+3:4k], bit j set => value j
//   out_valid  out  1   head entry is presented
//   out_ready  in   1   consumer takes the head entry this cycle
//   out_data   out  16  binary value, digit k in bits [2k+1:2k]
//   out_err    out  1   head entry had at least one malformed digit
//   err_mask   out  8   bit k set => digit k of head entry was malformed
//   err_count  out  8   accepted words with out_err set, saturates at 255
//   clr_cnt    in   1   synchronously clears err_count
module onehot_to_binary_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_err,
  output logic [7:0]  err_mask,
  output logic [7:0]  err_count,
  input  logic        clr_cnt
);

  localparam int DIGITS = 8;
  localparam int ENT_W  = 24;

  // Decode one nibble into {malformed, hi, lo}. The hi/lo decode is applied
  // unconditionally, so malformed nibbles still produce a defined value.
  function automatic logic [2:0] dec_nib(input logic [3:0] n);
    logic bad;
    bad = !((n == 4'b0001) || (n == 4'b0010) ||
            (n == 4'b0100) || (n == 4'b1000));
    return {bad, n[3] | n[2], n[3] | n[1]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]       occ_q, occ_d;
  logic [ENT_W-1:0] ent0_q, ent0_d;   // head entry {data, mask}
  logic [ENT_W-1:0] ent1_q, ent1_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [15:0]      dec_bin;
  logic [7:0]       dec_mask;
  logic [ENT_W-1:0] new_ent;
  logic             push, pop;

  // Combinational decode and check of the incoming word
  always_comb begin
    logic [2:0] d;
    dec_bin  = '0;
    dec_mask = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d                  = dec_nib(in_data[4*k +: 4]);
      dec_bin[2*k +: 2]  = d[1:0];
      dec_mask[k]        = d[2];
    end
  end

  assign new_ent = {dec_bin, dec_mask};

  // Ready depends only on registered occupancy and reset
  assign in_ready  = rst_n & (occ_q != 2'd2);
  assign out_valid = rst_n & (occ_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data  = out_valid ? ent0_q[ENT_W-1:8] : 16'h0000;
  assign err_mask  = out_valid ? ent0_q[7:0] : 8'h00;
  assign out_err   = |err_mask;
  assign err_count = rst_n ? cnt_q : 8'h00;

  // FIFO next state: entry 0 is always the head, entry 1 the tail
  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = new_ent;
        else               ent1_d = new_ent;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      // Push with pop only occurs at occupancy 1: the new word becomes head
      2'b11: ent0_d = new_ent;
      default: ;
    endcase
  end

  // Error counter: clear has priority over an erroneous accept
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)                  cnt_d = 8'h00;
    else if (push && |dec_mask)   cnt_d = sat_inc(cnt_q);
  end

  // Stage boundary: control state (reset applies here only)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= 2'd0;
      cnt_q <= 8'h00;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  // Stage boundary: buffer storage, qualified by occupancy instead of reset
  always_ff @(posedge clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

endmodule

// File: tb/tb_onehot_to_binary_16.sv
module tb_onehot_to_binary_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;
  logic [7:0]  err_mask;
  logic [7:0]  err_count;
  logic        clr_cnt;

  int nvec = 0;
  int nmis = 0;

  onehot_to_binary_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_mask  (err_mask),
    .err_count (err_count),
    .clr_cnt   (clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] d, input logic [7:0] m);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".data"},  out_data, d);
    chk({tag, ".mask"},  err_mask, m);
    chk({tag, ".err"},   out_err, |m);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_cnt = 1'b0;
    step(); step();
    chk("rst.in_ready",  in_ready,  1'b0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.out_data",  out_data,  16'h0);
    chk("rst.err_count", err_count, 8'h0);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", in_ready, 1'b1);

    // Basic conversion
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h12141821;
    step();
    chk_head("w1234", 16'h1234, 8'h00);

    in_data = 32'h88888888; step();
    chk_head("wFFFF", 16'hFFFF, 8'h00);
    in_data = 32'h11111111; step();
    chk_head("w0000", 16'h0000, 8'h00);
    chk("cnt.clean", err_count, 8'h0);
    in_valid = 1'b0; step();
    chk("empty.valid", out_valid, 1'b0);
    chk("empty.data",  out_data,  16'h0);
    chk("empty.err",   out_err,   1'b0);

    // Malformed digits
    in_valid = 1'b1; in_data = 32'h11111113; step();
    chk_head("bad3", 16'h0001, 8'h01);
    chk("cnt.one", err_count, 8'h1);
    in_data = 32'h00000000; step();
    chk_head("bad0", 16'h0000, 8'hFF);
    chk("cnt.two", err_count, 8'h2);
    in_valid = 1'b0; step();

    // Back-pressure: A, B accepted, C held off
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h88888888; step();
    chk("stA.in_ready", in_ready, 1'b1);
    chk_head("stA", 16'hFFFF, 8'h00);
    in_data = 32'h11111111; step();
    chk("stB.in_ready", in_ready, 1'b0);
    chk_head("stB", 16'hFFFF, 8'h00);
    in_data = 32'h12141821; step();
    chk("stC.in_ready", in_ready, 1'b0);
    chk_head("stC", 16'hFFFF, 8'h00);
    step();
    chk_head("stHold", 16'hFFFF, 8'h00);
    out_ready = 1'b1; step();
    chk("drA.in_ready", in_ready, 1'b1);
    chk_head("drB", 16'h0000, 8'h00);
    step();
    chk_head("drC", 16'h1234, 8'h00);
    in_valid = 1'b0; step();
    chk("drEmpty.valid", out_valid, 1'b0);
    chk("drCnt", err_count, 8'h2);

    // Saturation
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    chk("clr", err_count, 8'h0);
    in_valid = 1'b1; in_data = 32'h00000000;
    for (int i = 1; i <= 260; i++) begin
      step();
      if (i == 254) chk("sat.254", err_count, 8'd254);
    end
    chk("sat.255", err_count, 8'd255);
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    chk("clr.prio", err_count, 8'h0);
    step();
    chk("clr.after", err_count, 8'h1);
    in_valid = 1'b0; step();

    // Reset mid-stream with a full buffer
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h88888888; step();
    in_data = 32'h44444444; step();
    chk("full.in_ready", in_ready, 1'b0);
    chk_head("full", 16'hFFFF, 8'h00);
    in_valid = 1'b0; rst_n = 1'b0; #1;
    chk("mrst.out_valid", out_valid, 1'b0);
    chk("mrst.err_count", err_count, 8'h0);
    chk("mrst.in_ready",  in_ready,  1'b0);
    step();
    rst_n = 1'b1; #1;
    chk("mrel.in_ready",  in_ready,  1'b1);
    chk("mrel.out_valid", out_valid, 1'b0);
    chk("mrel.err_count", err_count, 8'h0);
    out_ready = 1'b1; step(); step();
    chk("mrel.stale", out_valid, 1'b0);
    in_valid = 1'b1; in_data = 32'h44444444; step();
    chk_head("post", 16'hAAAA, 8'h00);
    in_valid = 1'b0; step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/onehot_to_binary_16.md
# onehot_to_binary_16

Downstream unpack stage for the one-hot quaternary adder. It accepts the adder's registered 32-bit result, which holds eight base-4 digits, each encoded one-hot in a nibble. Each accepted word is checked for per-digit one-hot validity, converted to a 16-bit binary value, and queued in a 2-entry buffer behind a valid/ready handshake. A saturating counter records how many accepted words contained malformed digits.

## Interface
- No parameters; all widths are fixed for the 8-digit / 16-bit datapath.
- clk  in  1  Single clock, rising-edge.
- rst_n  in  1  Reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  in_data holds a result word.
- in_ready  out  1  Block can accept a word this cycle.
- in_data  in  32  Digit k occupies bits [4k+3:4k]. Bit j of that nibble set means digit value j (0..3).
- out_valid  out  1  Head buffer entry is presented.
- out_ready  in  1  Consumer takes the head entry this cycle.
- out_data  out  16  Binary value. Digit k maps to bits [2k+1:2k].
- out_err  out  1  Head entry had at least one malformed digit.
- err_mask  out  8  Bit k set means digit k of the head entry was malformed.
- err_count  out  8  Number of accepted words with out_err set; saturates at 255.
- clr_cnt  in  1  Synchronously clears err_count.

## Operation
- Accept when in_valid & in_ready at a rising edge. Pop when out_valid & out_ready at a rising edge.
- Per-digit decode, for nibble n:
  - hi bit = n[3] | n[2]
  - lo bit = n[3] | n[1]
  - This decode is applied even to malformed nibbles; no substitution is made.
- A digit is malformed when its nibble does not have exactly one bit set. This includes 0x0 and any nibble with two or more bits set.
- out_err for an entry is the OR of its 8-bit err_mask.
- Decode and check are combinational on in_data. Each buffer entry stores {out_data, err_mask}, 24 bits.
- Buffer: 2-entry FIFO with occupancy counter 0..2.
  - in_ready = rst_n & (occupancy != 2).
  - out_valid = (occupancy != 0).
- Simultaneous push and pop:
  - Occupancy 1: occupancy stays 1. The head becomes the new word.
  - Occupancy 2: push is impossible because in_ready is 0; the pop alone proceeds.
- FIFO order is strict. No word may be dropped or duplicated.
- When the buffer is empty, out_data, err_mask and out_err are driven to 0.
- err_count increments on accept of a word with out_err=1, and stops at 255 (no wrap).
  - clr_cnt has priority: clr_cnt=1 forces 0, even with a simultaneous erroneous accept.
  - The count is taken at accept time, so consumer stalls do not affect it.

## Timing
- Reset (rst_n=0 at an edge) sets occupancy=0 and err_count=0. All buffered entries are discarded.
  - While rst_n=0: in_ready=0, out_valid=0, out_data=0, err_mask=0, out_err=0, err_count=0.
- Reset asserted mid-stream: buffered words are lost. After release, in_ready=1 in the first cycle with rst_n=1.
- Latency: a word accepted at edge N is presented on out_data at edge N+1 when the buffer was empty.
- Throughput: one word per cycle while out_ready=1.
- in_ready has no combinational path from in_valid or in_data. It depends only on registered occupancy and rst_n.
- No combinational path from in_data to out_data; outputs come from buffer registers.
- Holding rule: while out_valid=1 and out_ready=0, the head entry and all of its outputs are held stable.

## Test plan
- Accept 0x12141821 with out_ready=1: one cycle later out_valid=1, out_data=0x1234, err_mask=0x00, out_err=0.
- Send 0x88888888, then 0x11111111, back-to-back with out_ready=1: outputs 0xFFFF then 0x0000, each with out_err=0 and err_count unchanged.
- Send 0x11111113, then 0x00000000:
  - First word: out_data=0x0001, err_mask=0x01.
  - Second word: out_data=0x0000, err_mask=0xFF.
  - err_count=2.
- Hold out_ready=0 and offer 3 words (A, B, C): in_ready drops after 2 accepts and C is held off. Raise out_ready: A, B, C emerge in order, and the head stays stable throughout the stall.
- err_count behaviour:
  - Drive 260 erroneous words: err_count ends at 255.
  - Pulse clr_cnt together with an erroneous accept: err_count=0.
- Fill the buffer with 2 words, then pulse rst_n=0 for one cycle: out_valid=0, err_count=0, and in_ready=1 on the first cycle after release. The old words never appear.
